sram_slot_arbiter: RTL and testbench

- Parametrised successor to the single-owner SRAM hand-over in the top level. Time-multiplexes the one external 16-bit SRAM among N_CLIENTS effect clients (delay, looper, future reverb) once per audio frame.
- Serves each requesting client at most once per frame, in round-robin order, with a fixed multi-cycle access waveform.
- Owns the SRAM address, write-enable and data-output-enable pins; the top level only instantiates the tristate buffer.

---
 rtl/sram_arb_pkg.sv | 23 ++
 rtl/rr_pick.sv | 48 ++++
 rtl/sram_slot_arbiter.sv | 179 +++++++++++++++++
 tb/tb_sram_slot_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// ---------------------------------------------------------------------------
// sram_arb_pkg
// Shared definitions for the SRAM slot arbiter:
//   - arb_state_t      : arbiter FSM state encoding (IDLE / ARB / ACCESS)
//   - DEF_ADDR_W/DATA_W: default SRAM address / data widths
//   - CLI_*            : fixed client slot indices used by the top level
// ---------------------------------------------------------------------------
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARB    = 2'd1,
        ACCESS = 2'd2
    } arb_state_t;

    localparam int DEF_ADDR_W = 20;
    localparam int DEF_DATA_W = 16;

    localparam int CLI_DELAY = 0;
    localparam int CLI_LOOP  = 1;
    localparam int CLI_SPARE = 2;

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker. Selects the first set bit of
// i_elig at or after position i_ptr, wrapping modulo N.
// Ports:
//   i_elig  [N-1:0]     eligible clients
//   i_ptr   [IDX_W-1:0] highest-priority position (must be < N)
//   o_gnt   [N-1:0]     one-hot pick, all zero when i_elig is empty
//   o_idx   [IDX_W-1:0] index of the pick, zero when i_elig is empty
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_elig,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx
);

    logic             w_found;
    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_cand;

    // NOTE: every signal written in always_comb gets a default first so that
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_cand  = '0;
        for (int i = 0; i < N; i++) begin
            // Candidate position ptr+i, folded back into 0..N-1.
            w_sum = {1'b0, i_ptr} + (IDX_W+1)'(i);
            if (w_sum >= (IDX_W+1)'(N)) begin
                w_sum = w_sum - (IDX_W+1)'(N);
            end
            w_cand = w_sum[IDX_W-1:0];
            if (!w_found && i_elig[w_cand]) begin
                w_found       = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_idx         = w_cand;
            end
        end
    end

endmodule

// File: rtl/sram_slot_arbiter.sv
// ---------------------------------------------------------------------------
// sram_slot_arbiter
// Time-multiplexes one external SRAM among N_CLIENTS clients. Each frame
// (i_frame_start) every requesting client is served at most once, in
// round-robin order, with a fixed ACCESS_CYC-cycle access waveform.
// Ports:
//   i_clk, i_rst         clock, asynchronous active-high reset
//   i_frame_start        one-cycle pulse per sample frame
//   i_req/i_we_n         per-client request level / access type (0 = write)
//   i_addr/i_wdata       packed per-client address / write data
//   o_gnt/o_ack          one-hot current owner / one-cycle completion pulse
//   o_rdata              read data, valid with o_ack
//   o_sram_*             SRAM address, write enable, DQ drive enable/value
//   i_sram_rdata         DQ input value
//   o_busy/o_overrun     FSM not idle / sticky frame overrun
// ---------------------------------------------------------------------------
module sram_slot_arbiter
    import sram_arb_pkg::*;
#(
    parameter int N_CLIENTS  = 3,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ACCESS_CYC = 3
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_frame_start,
    input  logic [N_CLIENTS-1:0]        i_req,
    input  logic [N_CLIENTS-1:0]        i_we_n,
    input  logic [N_CLIENTS*ADDR_W-1:0] i_addr,
    input  logic [N_CLIENTS*DATA_W-1:0] i_wdata,
    output logic [N_CLIENTS-1:0]        o_gnt,
    output logic [N_CLIENTS-1:0]        o_ack,
    output logic [DATA_W-1:0]           o_rdata,
    output logic [ADDR_W-1:0]           o_sram_addr,
    output logic                        o_sram_we_n,
    output logic                        o_sram_dq_oe,
    output logic [DATA_W-1:0]           o_sram_wdata,
    input  logic [DATA_W-1:0]           i_sram_rdata,
    output logic                        o_busy,
    output logic                        o_overrun
);

    localparam int IDX_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam int CNT_W = $clog2(ACCESS_CYC);

    arb_state_t             r_state;
    arb_state_t             w_state_nxt;
    logic [N_CLIENTS-1:0]   r_served;
    logic [N_CLIENTS-1:0]   w_served_nxt;
    logic [IDX_W-1:0]       r_ptr;
    logic [CNT_W-1:0]       r_cnt;
    logic [ADDR_W-1:0]      r_lat_addr;
    logic                   r_lat_we_n;
    logic [DATA_W-1:0]      r_lat_wdata;
    logic [IDX_W-1:0]       r_lat_idx;
    logic [N_CLIENTS-1:0]   r_gnt;
    logic [N_CLIENTS-1:0]   r_ack;
    logic [DATA_W-1:0]      r_rdata;
    logic                   r_overrun;

    logic [N_CLIENTS-1:0]   w_elig;
    logic [N_CLIENTS-1:0]   w_pick_gnt;
    logic [IDX_W-1:0]       w_pick_idx;
    logic                   w_in_access;
    logic                   w_last;
    logic                   w_arb_empty;
    logic                   w_write;

    assign w_elig      = i_req & ~r_served;
    assign w_in_access = (r_state == ACCESS);
    assign w_last      = w_in_access && (r_cnt == CNT_W'(ACCESS_CYC - 1));
    assign w_arb_empty = (r_state == ARB) && (w_elig == '0);
    assign w_write     = w_in_access && !r_lat_we_n;

    rr_pick #(
        .N     (N_CLIENTS),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_elig (w_elig),
        .i_ptr  (r_ptr),
        .o_gnt  (w_pick_gnt),
        .o_idx  (w_pick_idx)
    );

    // Next-state decode. A frame start that coincides with an empty ARB
    // re-arbitrates for the new frame instead of parking in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_frame_start) w_state_nxt = ARB;
            ARB: begin
                if (w_elig != '0)        w_state_nxt = ACCESS;
                else if (i_frame_start)  w_state_nxt = ARB;
                else                     w_state_nxt = IDLE;
            end
            ACCESS:  if (w_last) w_state_nxt = ARB;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Served mask: a frame start opens a new frame; a completing access is
    // recorded afterwards so it counts against the frame it finished in.
    always_comb begin
        w_served_nxt = i_frame_start ? '0 : r_served;
        if (w_last) begin
            w_served_nxt = w_served_nxt | r_gnt;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_served    <= '0;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_lat_addr  <= '0;
            r_lat_we_n  <= 1'b1;
            r_lat_wdata <= '0;
            r_lat_idx   <= '0;
            r_gnt       <= '0;
            r_ack       <= '0;
            r_rdata     <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_served <= w_served_nxt;
            r_ack    <= '0;

            if (i_frame_start && (r_state != IDLE) && !w_arb_empty) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                ARB: begin
                    if (w_elig != '0) begin
                        r_lat_addr  <= i_addr[w_pick_idx*ADDR_W +: ADDR_W];
                        r_lat_wdata <= i_wdata[w_pick_idx*DATA_W +: DATA_W];
                        r_lat_we_n  <= i_we_n[w_pick_idx];
                        r_lat_idx   <= w_pick_idx;
                        r_gnt       <= w_pick_gnt;
                        r_cnt       <= '0;
                    end
                end
                ACCESS: begin
                    if (w_last) begin
                        r_ack <= r_gnt;
                        r_gnt <= '0;
                        r_ptr <= (r_lat_idx == IDX_W'(N_CLIENTS - 1))
                                 ? '0 : r_lat_idx + IDX_W'(1);
                        if (r_lat_we_n) begin
                            r_rdata <= i_sram_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // SRAM pins decode purely from registered state, so reset forces them
    // safe immediately. WE is low only on the inner cycles of a write,
    // leaving the first and last cycle as address setup and data hold.
    assign o_sram_addr  = w_in_access ? r_lat_addr : '0;
    assign o_sram_dq_oe = w_write;
    assign o_sram_we_n  = !(w_write && (r_cnt != '0) && !w_last);
    assign o_sram_wdata = w_write ? r_lat_wdata : '0;

    assign o_gnt     = r_gnt;
    assign o_ack     = r_ack;
    assign o_rdata   = r_rdata;
    assign o_busy    = (r_state != IDLE);
    assign o_overrun = r_overrun;

endmodule

// File: tb/tb_sram_slot_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_slot_arbiter
// Directed self-checking bench for sram_slot_arbiter (N_CLIENTS=3,
// ACCESS_CYC=3). Inputs change and outputs are sampled 1 ns after each
// rising clock edge.
// ---------------------------------------------------------------------------
module tb_sram_slot_arbiter;
    import sram_arb_pkg::*;

    localparam int N  = 3;
    localparam int AW = 20;
    localparam int DW = 16;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic            i_frame_start;
    logic [N-1:0]    i_req;
    logic [N-1:0]    i_we_n;
    logic [N*AW-1:0] i_addr;
    logic [N*DW-1:0] i_wdata;
    logic [N-1:0]    o_gnt;
    logic [N-1:0]    o_ack;
    logic [DW-1:0]   o_rdata;
    logic [AW-1:0]   o_sram_addr;
    logic            o_sram_we_n;
    logic            o_sram_dq_oe;
    logic [DW-1:0]   o_sram_wdata;
    logic [DW-1:0]   i_sram_rdata;
    logic            o_busy;
    logic            o_overrun;

    int n_vec = 0;
    int n_err = 0;

    sram_slot_arbiter #(
        .N_CLIENTS  (N),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .ACCESS_CYC (3)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_frame_start (i_frame_start),
        .i_req         (i_req),
        .i_we_n        (i_we_n),
        .i_addr        (i_addr),
        .i_wdata       (i_wdata),
        .o_gnt         (o_gnt),
        .o_ack         (o_ack),
        .o_rdata       (o_rdata),
        .o_sram_addr   (o_sram_addr),
        .o_sram_we_n   (o_sram_we_n),
        .o_sram_dq_oe  (o_sram_dq_oe),
        .o_sram_wdata  (o_sram_wdata),
        .i_sram_rdata  (i_sram_rdata),
        .o_busy        (o_busy),
        .o_overrun     (o_overrun)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst         = 1'b1;
        i_frame_start = 1'b0;
        i_req         = '0;
        tick();
        i_rst = 1'b0;
    endtask

    // Pulse i_frame_start for one cycle; returns in the ARB cycle.
    task automatic start_frame();
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
    endtask

    // From an ARB cycle: expect client g to own ACCESS, then its ack.
    task automatic serve(input int g, input string tag);
        tick();
        check({tag, "_gnt"}, 32'(o_gnt), 32'(1 << g));
        tick();
        tick();
        tick();
        check({tag, "_ack"}, 32'(o_ack), 32'(1 << g));
    endtask

    // From an ARB cycle with nothing eligible: expect IDLE next.
    task automatic end_frame(input string tag);
        tick();
        check({tag, "_idle"}, 32'(o_busy), 32'd0);
    endtask

    initial begin
        i_rst         = 1'b1;
        i_frame_start = 1'b0;
        i_req         = '0;
        i_we_n        = '1;
        i_addr        = '0;
        i_wdata       = '0;
        i_sram_rdata  = '0;
        #1;
        // ---- reset values ----
        check("rst_addr", 32'(o_sram_addr), 32'd0);
        check("rst_we_n", 32'(o_sram_we_n), 32'd1);
        check("rst_oe",   32'(o_sram_dq_oe), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_ovr",  32'(o_overrun), 32'd0);
        check("rst_gnt",  32'(o_gnt), 32'd0);
        tick();
        i_rst = 1'b0;

        // ---- reset in the middle of a write by the spare client ----
        i_req[CLI_SPARE]                = 1'b1;
        i_we_n                          = 3'b011;
        i_addr[CLI_SPARE*AW +: AW]      = 20'h00055;
        i_wdata[CLI_SPARE*DW +: DW]     = 16'hA5A5;
        start_frame();
        tick();
        check("mid_gnt", 32'(o_gnt), 32'b100);
        tick();
        check("mid_we_low", 32'(o_sram_we_n), 32'd0);
        #2 i_rst = 1'b1;
        #1;
        check("mid_rst_we_n", 32'(o_sram_we_n), 32'd1);
        check("mid_rst_oe",   32'(o_sram_dq_oe), 32'd0);
        check("mid_rst_gnt",  32'(o_gnt), 32'd0);
        i_req = '0;
        tick();
        i_rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("mid_no_ack", 32'(o_ack), 32'd0);
        end

        // ---- single write, client 0 drops i_req mid-access ----
        do_reset();
        i_req                       = 3'b001;
        i_we_n                      = 3'b110;
        i_addr[CLI_DELAY*AW +: AW]  = 20'h00010;
        i_wdata[CLI_DELAY*DW +: DW] = 16'h1234;
        start_frame();
        check("wr_arb_busy", 32'(o_busy), 32'd1);
        check("wr_arb_oe",   32'(o_sram_dq_oe), 32'd0);
        tick();
        i_req = '0;
        i_wdata[CLI_DELAY*DW +: DW] = 16'hFFFF;
        check("wr_c0_addr", 32'(o_sram_addr), 32'h00010);
        check("wr_c0_we",   32'(o_sram_we_n), 32'd1);
        check("wr_c0_oe",   32'(o_sram_dq_oe), 32'd1);
        check("wr_c0_data", 32'(o_sram_wdata), 32'h1234);
        check("wr_c0_gnt",  32'(o_gnt), 32'b001);
        tick();
        check("wr_c1_addr", 32'(o_sram_addr), 32'h00010);
        check("wr_c1_we",   32'(o_sram_we_n), 32'd0);
        check("wr_c1_data", 32'(o_sram_wdata), 32'h1234);
        tick();
        check("wr_c2_we",   32'(o_sram_we_n), 32'd1);
        check("wr_c2_oe",   32'(o_sram_dq_oe), 32'd1);
        check("wr_c2_ack",  32'(o_ack), 32'd0);
        tick();
        check("wr_ack",     32'(o_ack), 32'b001);
        check("wr_ack_gnt", 32'(o_gnt), 32'd0);
        check("wr_ack_oe",  32'(o_sram_dq_oe), 32'd0);
        end_frame("wr");
        check("wr_ack_gone", 32'(o_ack), 32'd0);

        // ---- read by client 1 ----
        do_reset();
        i_req                      = 3'b010;
        i_we_n                     = 3'b111;
        i_addr[CLI_LOOP*AW +: AW]  = 20'h0ABCD;
        i_sram_rdata               = 16'hBEEF;
        start_frame();
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rd_addr", 32'(o_sram_addr), 32'h0ABCD);
            check("rd_oe",   32'(o_sram_dq_oe), 32'd0);
            check("rd_we",   32'(o_sram_we_n), 32'd1);
            check("rd_gnt",  32'(o_gnt), 32'b010);
        end
        tick();
        check("rd_ack",   32'(o_ack), 32'b010);
        check("rd_rdata", 32'(o_rdata), 32'hBEEF);
        i_req        = '0;
        i_sram_rdata = 16'h0000;
        end_frame("rd");
        check("rd_hold", 32'(o_rdata), 32'hBEEF);

        // ---- round-robin over two frames, all requests held ----
        do_reset();
        i_req = 3'b111;
        start_frame();
        serve(0, "rr1_a");
        serve(1, "rr1_b");
        serve(2, "rr1_c");
        end_frame("rr1");
        start_frame();
        serve(0, "rr2_a");
        serve(1, "rr2_b");
        serve(2, "rr2_c");
        end_frame("rr2");
        check("rr_no_ovr", 32'(o_overrun), 32'd0);

        // ---- rotation: pointer left at 2 by a client-1-only frame ----
        do_reset();
        i_req = 3'b010;
        start_frame();
        serve(1, "rot1");
        end_frame("rot1");
        i_req = 3'b111;
        start_frame();
        serve(2, "rot2_a");
        serve(0, "rot2_b");
        serve(1, "rot2_c");
        end_frame("rot2");

        // ---- frame start on the empty-ARB decision: re-arbitrate, no overrun ----
        do_reset();
        i_req = 3'b001;
        start_frame();
        serve(0, "edge1");
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
        check("edge_busy", 32'(o_busy), 32'd1);
        check("edge_ovr",  32'(o_overrun), 32'd0);
        serve(0, "edge2");
        end_frame("edge");
        check("edge_ovr_end", 32'(o_overrun), 32'd0);

        // ---- overrun during client 1's access ----
        do_reset();
        i_req = 3'b111;
        start_frame();
        serve(0, "ovr_a");
        tick();
        check("ovr_b_gnt", 32'(o_gnt), 32'b010);
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
        check("ovr_set",   32'(o_overrun), 32'd1);
        check("ovr_b_gnt2", 32'(o_gnt), 32'b010);
        tick();
        tick();
        check("ovr_b_ack", 32'(o_ack), 32'b010);
        serve(2, "ovr_c");
        serve(0, "ovr_d");
        end_frame("ovr");
        check("ovr_sticky", 32'(o_overrun), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
